mem_access_arbiter: RTL and testbench

- Shares one single-ported memory between the instruction-fetch requester and the data (load/store) requester.
- Sequences each access through a request/grant/response handshake with the memory.
- Returns a one-cycle acknowledge per access; d_ack_o drives the control unit's mem_ack_i, which holds the pipeline stall until the access completes.
- Enforces fairness between the two requesters and recovers from an unresponsive memory through a timeout.

---
 rtl/mem_access_arbiter_if.sv | 38 +++
 rtl/mem_access_arbiter.sv | 85 ++++++++
 tb/tb_mem_access_arbiter.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/mem_access_arbiter_if.sv
// mem_access_arbiter_if: requester, memory and status signals of the memory arbiter
interface mem_access_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              d_read_i;
  logic              d_write_i;
  logic [ADDR_W-1:0] d_addr_i;
  logic [DATA_W-1:0] d_wdata_i;
  logic [DATA_W-1:0] d_rdata_o;
  logic              d_ack_o;
  logic              d_err_o;
  logic              f_req_i;
  logic [ADDR_W-1:0] f_addr_i;
  logic [DATA_W-1:0] f_rdata_o;
  logic              f_ack_o;
  logic              f_err_o;
  logic              m_req_o;
  logic              m_we_o;
  logic [ADDR_W-1:0] m_addr_o;
  logic [DATA_W-1:0] m_wdata_o;
  logic              m_gnt_i;
  logic              m_rvalid_i;
  logic [DATA_W-1:0] m_rdata_i;
  logic              busy_o;
  modport slave (
    input  d_read_i, d_write_i, d_addr_i, d_wdata_i, f_req_i, f_addr_i,
           m_gnt_i, m_rvalid_i, m_rdata_i,
    output d_rdata_o, d_ack_o, d_err_o, f_rdata_o, f_ack_o, f_err_o,
           m_req_o, m_we_o, m_addr_o, m_wdata_o, busy_o
  );
  modport master (
    output d_read_i, d_write_i, d_addr_i, d_wdata_i, f_req_i, f_addr_i,
           m_gnt_i, m_rvalid_i, m_rdata_i,
    input  d_rdata_o, d_ack_o, d_err_o, f_rdata_o, f_ack_o, f_err_o,
           m_req_o, m_we_o, m_addr_o, m_wdata_o, busy_o
  );
endinterface

// File: rtl/mem_access_arbiter.sv
// mem_access_arbiter: shares one memory port between fetch and data requesters with fairness and timeout
module mem_access_arbiter #(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int MAX_DATA_STREAK = 4,
  parameter int TIMEOUT         = 64
) (
  input logic                 clock,
  input logic                 reset,
  mem_access_arbiter_if.slave bus
);
  localparam int SW = $clog2(MAX_DATA_STREAK + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;
  state_t            state, state_nx;
  logic [SW-1:0]     streak;
  logic [TW-1:0]     timer;
  logic              own_f, own_we, err;
  logic [ADDR_W-1:0] own_addr;
  logic [DATA_W-1:0] own_wdata, d_rdata, f_rdata;
  logic              d_req, d_bad, f_win, grant, time_up;
  assign d_req   = bus.d_read_i | bus.d_write_i;
  assign d_bad   = bus.d_read_i & bus.d_write_i;
  assign f_win   = bus.f_req_i && (!d_req || streak == SW'(MAX_DATA_STREAK));
  assign grant   = state == IDLE && (f_win || d_req);
  assign time_up = timer == TW'(TIMEOUT - 1);
  // state register
  always_ff @(posedge clock or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nx;
  // next state: arbitration in IDLE, handshake progress or timeout elsewhere
  always_comb begin
    state_nx = IDLE;
    unique case (state)
      IDLE: state_nx = f_win ? REQ : d_req ? (d_bad ? DONE : REQ) : IDLE;
      REQ:  state_nx = bus.m_gnt_i ? RESP : time_up ? DONE : REQ;
      RESP: state_nx = bus.m_rvalid_i || time_up ? DONE : RESP;
      DONE: state_nx = IDLE;
    endcase
  end
  // owner latch, fairness streak, progress timer and completion data
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      streak    <= '0;
      timer     <= '0;
      own_f     <= 1'b0;
      own_we    <= 1'b0;
      err       <= 1'b0;
      own_addr  <= '0;
      own_wdata <= '0;
      d_rdata   <= '0;
      f_rdata   <= '0;
    end else begin
      if (grant) begin
        own_f     <= f_win;
        own_we    <= !f_win && bus.d_write_i;
        own_addr  <= f_win ? bus.f_addr_i : bus.d_addr_i;
        own_wdata <= f_win ? '0 : bus.d_wdata_i;
        err       <= !f_win && d_bad;
        streak    <= f_win || !bus.f_req_i ? '0 :
                     streak == SW'(MAX_DATA_STREAK) ? streak : streak + 1'b1;
      end
      timer <= (state == REQ || state == RESP) && state_nx == state ? timer + 1'b1 : '0;
      if ((state == REQ && !bus.m_gnt_i && time_up) || (state == RESP && !bus.m_rvalid_i && time_up))
        err <= 1'b1;
      if (state == RESP && bus.m_rvalid_i) begin
        if (own_f) f_rdata <= bus.m_rdata_i;
        else d_rdata <= bus.m_rdata_i;
      end
    end
  // outputs decoded from state and the owner register
  always_comb begin
    bus.m_req_o   = state == REQ;
    bus.m_we_o    = own_we;
    bus.m_addr_o  = own_addr;
    bus.m_wdata_o = own_wdata;
    bus.d_ack_o   = state == DONE && !own_f;
    bus.f_ack_o   = state == DONE && own_f;
    bus.d_err_o   = state == DONE && !own_f && err;
    bus.f_err_o   = state == DONE && own_f && err;
    bus.d_rdata_o = d_rdata;
    bus.f_rdata_o = f_rdata;
    bus.busy_o    = state != IDLE;
  end
endmodule

// File: tb/tb_mem_access_arbiter.sv
// tb_mem_access_arbiter: directed vectors against hand-computed arbiter behaviour
module tb_mem_access_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        gnt_en = 1'b0, rv_en = 1'b0, stray = 1'b0, rv = 1'b0;
  logic [31:0] rdata_val = '0;
  int          vectors = 0, errors = 0;
  mem_access_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
  mem_access_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_DATA_STREAK(4), .TIMEOUT(64)) dut (
    .clock(clk),
    .reset(rst),
    .bus  (bus)
  );
  always #5 clk = ~clk;
  assign bus.m_gnt_i    = bus.m_req_o & gnt_en;
  assign bus.m_rvalid_i = rv | stray;
  assign bus.m_rdata_i  = rdata_val;
  always @(posedge clk) rv <= bus.m_req_o & bus.m_gnt_i & rv_en;
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_ack(output logic d, output logic f);
    int n = 0;
    do begin
      step();
      n++;
    end while (!(bus.d_ack_o || bus.f_ack_o) && n < 100);
    d = bus.d_ack_o;
    f = bus.f_ack_o;
    chk("ack_seen", 32'(d | f), 1);
  endtask
  initial begin
    logic d, f, seen;
    int   n;
    bus.d_read_i = 0; bus.d_write_i = 0; bus.d_addr_i = '0; bus.d_wdata_i = '0;
    bus.f_req_i = 0; bus.f_addr_i = '0;
    step();
    step();
    chk("rst_busy", 32'(bus.busy_o), 0);
    chk("rst_mreq", 32'(bus.m_req_o), 0);
    chk("rst_maddr", bus.m_addr_o, 0);
    chk("rst_acks", 32'({bus.d_ack_o, bus.f_ack_o, bus.d_err_o, bus.f_err_o}), 0);
    chk("rst_rdata", bus.d_rdata_o | bus.f_rdata_o, 0);
    rst = 0;
    gnt_en = 1; rv_en = 1; rdata_val = 32'hDEADBEEF;
    bus.d_read_i = 1; bus.d_addr_i = 32'h40;
    step();
    chk("ld_mreq", 32'(bus.m_req_o), 1);
    chk("ld_maddr", bus.m_addr_o, 32'h40);
    chk("ld_we", 32'(bus.m_we_o), 0);
    bus.d_read_i = 0; bus.d_addr_i = 32'h44;
    step();
    chk("ld_resp_mreq", 32'(bus.m_req_o), 0);
    chk("ld_resp_busy", 32'(bus.busy_o), 1);
    step();
    chk("ld_ack", 32'(bus.d_ack_o), 1);
    chk("ld_rdata", bus.d_rdata_o, 32'hDEADBEEF);
    chk("ld_err", 32'(bus.d_err_o), 0);
    chk("ld_fack", 32'(bus.f_ack_o), 0);
    step();
    chk("ld_ack_end", 32'(bus.d_ack_o), 0);
    chk("ld_rdata_hold", bus.d_rdata_o, 32'hDEADBEEF);
    bus.d_write_i = 1; bus.d_addr_i = 32'h80; bus.d_wdata_i = 32'h1234;
    step();
    chk("st_mreq", 32'(bus.m_req_o), 1);
    chk("st_we", 32'(bus.m_we_o), 1);
    chk("st_addr", bus.m_addr_o, 32'h80);
    chk("st_wdata", bus.m_wdata_o, 32'h1234);
    step();
    step();
    chk("st_ack", 32'(bus.d_ack_o), 1);
    chk("st_err", 32'(bus.d_err_o), 0);
    bus.d_write_i = 0;
    step();
    chk("st_ack_end", 32'(bus.d_ack_o), 0);
    bus.d_read_i = 1; bus.d_addr_i = 32'h200; bus.f_req_i = 1; bus.f_addr_i = 32'h300;
    for (int k = 0; k < 10; k++) begin
      rdata_val = 32'hC0DE0000 | 32'(k);
      wait_ack(d, f);
      chk($sformatf("order%0d", k), 32'(f), 32'(k == 4 || k == 9));
      chk($sformatf("crdata%0d", k), f ? bus.f_rdata_o : bus.d_rdata_o, 32'hC0DE0000 | 32'(k));
      step();
      chk($sformatf("pulse%0d", k), 32'(bus.d_ack_o | bus.f_ack_o), 0);
    end
    bus.d_read_i = 0; bus.f_req_i = 0;
    step();
    gnt_en = 0; bus.f_req_i = 1; bus.f_addr_i = 32'h100;
    step();
    chk("to_addr", bus.m_addr_o, 32'h100);
    n = 0;
    while (bus.m_req_o && n < 200) begin
      n++;
      step();
    end
    chk("to_req_cycles", 32'(n), 64);
    chk("to_fack", 32'(bus.f_ack_o), 1);
    chk("to_ferr", 32'(bus.f_err_o), 1);
    chk("to_mreq", 32'(bus.m_req_o), 0);
    chk("to_frdata", bus.f_rdata_o, 32'hC0DE0009);
    bus.f_req_i = 0;
    step();
    stray = 1;
    step();
    stray = 0;
    seen = 0;
    repeat (4) begin
      step();
      seen |= bus.d_ack_o | bus.f_ack_o;
    end
    chk("stray_noack", 32'(seen), 0);
    gnt_en = 1;
    bus.d_read_i = 1; bus.d_write_i = 1;
    step();
    chk("bad_mreq", 32'(bus.m_req_o), 0);
    chk("bad_ack", 32'(bus.d_ack_o), 1);
    chk("bad_err", 32'(bus.d_err_o), 1);
    bus.d_read_i = 0; bus.d_write_i = 0;
    step();
    chk("bad_ack_end", 32'({bus.d_ack_o, bus.m_req_o}), 0);
    rv_en = 0; bus.d_read_i = 1; bus.d_addr_i = 32'h500;
    step();
    step();
    chk("rr_in_resp", 32'({bus.busy_o, bus.m_req_o}), 32'b10);
    #1 rst = 1;
    #1;
    chk("rr_busy", 32'(bus.busy_o), 0);
    chk("rr_mreq", 32'(bus.m_req_o), 0);
    chk("rr_rdata", bus.d_rdata_o, 0);
    bus.d_read_i = 0;
    seen = 0;
    repeat (3) begin
      step();
      seen |= bus.d_ack_o | bus.f_ack_o;
    end
    rst = 0;
    repeat (3) begin
      step();
      seen |= bus.d_ack_o | bus.f_ack_o;
    end
    chk("rr_noack", 32'(seen), 0);
    rv_en = 1; rdata_val = 32'h55AA; bus.d_read_i = 1; bus.d_addr_i = 32'h600;
    wait_ack(d, f);
    chk("rr_next_d", 32'({d, f}), 32'b10);
    chk("rr_next_rdata", bus.d_rdata_o, 32'h55AA);
    bus.d_read_i = 0;
    step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end
endmodule
